// File: rtl/prince_pkg.sv
// prince_pkg: PRINCE ShiftRows nibble permutations and serial FSM state encoding
package prince_pkg;
   typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} sr_state_e;
   // nibble k of each table is the source index for output nibble k
   localparam logic [63:0] Q_TAB = 64'hFA50_B61C_72D8_3E94;
   localparam logic [63:0] P_TAB = 64'hF258_BE14_7AD0_369C;
   function automatic logic [3:0] q_idx(input logic [3:0] k);
      return Q_TAB[{k, 2'b00} +: 4];
   endfunction
   function automatic logic [3:0] p_idx(input logic [3:0] k);
      return P_TAB[{k, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/nibble_buf16.sv
// nibble_buf16: 16-entry register file, one write port, one combinational read port
module nibble_buf16 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         we_i,
   input  logic [3:0]   waddr_i,
   input  logic [W-1:0] wdata_i,
   input  logic [3:0]   raddr_i,
   output logic [W-1:0] rdata_o
);
   logic [W-1:0] mem_q [16];
   always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/prince_shiftrows_serial.sv
// prince_shiftrows_serial: nibble-serial forward/inverse ShiftRows over SHARES independent shares
module prince_shiftrows_serial
   import prince_pkg::*;
#(
   parameter int SHARES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mode,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*SHARES-1:0] in_nib,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*SHARES-1:0] out_nib,
   output logic                out_last
);
   sr_state_e  state_q;
   logic [3:0] wr_cnt_q, rd_cnt_q, rd_idx;
   logic       mode_q, in_acc, out_acc;
   assign in_ready  = state_q == LOAD;
   assign out_valid = state_q == DRAIN;
   assign out_last  = out_valid && rd_cnt_q == 4'hf;
   assign in_acc    = in_valid && in_ready;
   assign out_acc   = out_valid && out_ready;
   assign rd_idx    = mode_q ? p_idx(rd_cnt_q) : q_idx(rd_cnt_q);
   nibble_buf16 #(.W(4*SHARES)) u_buf (
      .clk     (clk),
      .we_i    (in_acc),
      .waddr_i (wr_cnt_q),
      .wdata_i (in_nib),
      .raddr_i (rd_idx),
      .rdata_o (out_nib)
   );
   // 4-bit counters wrap 15->0 on their own, so only the state needs an explicit turn-around
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= LOAD;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         mode_q   <= 1'b0;
      end else if (in_acc) begin
         wr_cnt_q <= wr_cnt_q + 4'd1;
         if (wr_cnt_q == 4'd0) mode_q <= mode;
         if (wr_cnt_q == 4'hf) state_q <= DRAIN;
      end else if (out_acc) begin
         rd_cnt_q <= rd_cnt_q + 4'd1;
         if (rd_cnt_q == 4'hf) state_q <= LOAD;
      end
   end
endmodule
